conv_maxpool2x2: RTL and testbench

- Streaming 2x2 max-pool stage placed directly downstream of the conv stage.
- Consumes the conv result stream (one sample per valid cycle, no backpressure) in raster order, ROW_W samples per row and ROWS rows per frame.
- Emits one pooled sample per 2x2 window.
- Uses a half-row line buffer, so a window is resolved in a single pass.

---
 rtl/conv_maxpool2x2.sv | 133 +++++++++++++
 tb/tb_conv_maxpool2x2.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/conv_maxpool2x2.sv
// Streaming 2x2 max-pool behind the conv stage, one pass through a half-row line buffer.
// Optional ReLU ahead of the compare when CONV_MAXPOOL_RELU_EN is defined.
module conv_maxpool2x2 #(
   parameter int DATA_W = 16,
   parameter int ROW_W  = 4,
   parameter int ROWS   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] pixel_in,
   output logic [DATA_W-1:0] pool_out,
   output logic              out_valid,
   output logic              frame_done
);

   localparam int LB_AW  = (ROW_W > 2) ? $clog2(ROW_W / 2) : 1;
   localparam int COL_W  = LB_AW + 1;
   localparam int ROW_AW = (ROWS > 2) ? $clog2(ROWS) : 1;
   localparam int LB_N   = 1 << LB_AW;

   function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
      if (a >= b) begin
         return a;
      end else begin
         return b;
      end
   endfunction

   function automatic logic [DATA_W-1:0] condition(input logic [DATA_W-1:0] x);
`ifdef CONV_MAXPOOL_RELU_EN
      if (x[DATA_W-1]) begin
         return {DATA_W{1'b0}};
      end else begin
         return x;
      end
`else
      return x;
`endif
   endfunction

   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_AW-1:0] row_q, row_d;
   logic [DATA_W-1:0] pair_q, pair_d;
   logic [DATA_W-1:0] pool_q, pool_d;
   logic              out_valid_q, out_valid_d;
   logic              frame_done_q, frame_done_d;
   logic [DATA_W-1:0] line_buf_q [LB_N];

   logic [DATA_W-1:0] s_s;
   logic [DATA_W-1:0] pair_max_s;
   logic [DATA_W-1:0] win_max_s;
   logic [LB_AW-1:0]  lb_idx_s;
   logic              lb_wr_en_s;
   logic              last_col_s;
   logic              last_row_s;

   // Next-state for counters, pair register and the registered outputs.
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      pair_d       = pair_q;
      pool_d       = pool_q;
      out_valid_d  = 1'b0;
      frame_done_d = 1'b0;
      lb_wr_en_s   = 1'b0;
      s_s          = condition(pixel_in);
      lb_idx_s     = col_q[COL_W-1:1];
      pair_max_s   = max_u(pair_q, s_s);
      win_max_s    = max_u(pair_max_s, line_buf_q[lb_idx_s]);
      last_col_s   = (col_q == COL_W'(ROW_W - 1));
      last_row_s   = (row_q == ROW_AW'(ROWS - 1));
      if (in_valid) begin
         // Even column parks the left sample; odd column closes a pair.
         if (col_q[0] == 1'b0) begin
            pair_d = s_s;
         end else if (row_q[0] == 1'b0) begin
            lb_wr_en_s = 1'b1;
         end else begin
            pool_d      = win_max_s;
            out_valid_d = 1'b1;
         end
         if (last_col_s) begin
            col_d = {COL_W{1'b0}};
            if (last_row_s) begin
               row_d        = {ROW_AW{1'b0}};
               frame_done_d = 1'b1;
            end else begin
               row_d = row_q + ROW_AW'(1);
            end
         end else begin
            col_d = col_q + COL_W'(1);
         end
      end else begin
         col_d = col_q;
         row_d = row_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q        <= {COL_W{1'b0}};
         row_q        <= {ROW_AW{1'b0}};
         pair_q       <= {DATA_W{1'b0}};
         pool_q       <= {DATA_W{1'b0}};
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         pool_q       <= pool_d;
         out_valid_q  <= out_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer holds even-row pair maxima; always written before it is read.
   always_ff @(posedge clk) begin
      if (lb_wr_en_s && !rst) begin
         line_buf_q[lb_idx_s] <= pair_max_s;
      end else begin
         line_buf_q[lb_idx_s] <= line_buf_q[lb_idx_s];
      end
   end

   assign pool_out   = pool_q;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_maxpool2x2.sv
// Directed bench for conv_maxpool2x2: frame-level window model plus literal expectations.
module tb_conv_maxpool2x2;
   localparam int DW = 16;
   localparam int RW = 4;
   localparam int RS = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] pixel_in = '0;
   logic [DW-1:0] pool_out;
   logic          out_valid;
   logic          frame_done;

   conv_maxpool2x2 #(.DATA_W(DW), .ROW_W(RW), .ROWS(RS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pixel_in(pixel_in),
      .pool_out(pool_out), .out_valid(out_valid), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   logic [DW-1:0] img [RS][RW];
   int            k = 0;
   logic          m_valid = 1'b0, m_fd = 1'b0;
   logic [DW-1:0] m_pool = '0;
   logic          exp_valid = 1'b0, exp_fd = 1'b0;
   logic [DW-1:0] exp_pool = '0;
   logic          chk_en = 1'b0;

   logic [DW-1:0] got [$];
   int            fd_cyc [$];

   logic [DW-1:0] fa [16];
   logic [DW-1:0] fb [16];
   logic [DW-1:0] fc [16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] cond(input logic [DW-1:0] d);
`ifdef CONV_MAXPOOL_RELU_EN
      return d[DW-1] ? 16'h0000 : d;
`else
      return d;
`endif
   endfunction

   function automatic logic [DW-1:0] mx(input logic [DW-1:0] a, input logic [DW-1:0] b);
      return (a > b) ? a : b;
   endfunction

   // One clock of stimulus; the model predicts what the outputs show after this edge.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
      @(negedge clk);
      in_valid = v;
      pixel_in = d;
      rst = r;
      m_valid = 1'b0;
      m_fd = 1'b0;
      if (r) begin
         k = 0;
         m_pool = '0;
      end else if (v) begin
         int rr;
         int cc;
         rr = (k / RW) % RS;
         cc = k % RW;
         img[rr][cc] = cond(d);
         if ((rr % 2 == 1) && (cc % 2 == 1)) begin
            m_valid = 1'b1;
            m_pool = mx(mx(img[rr-1][cc-1], img[rr-1][cc]), mx(img[rr][cc-1], img[rr][cc]));
            m_fd = (rr == RS - 1) && (cc == RW - 1);
         end
         k = (k + 1) % (RW * RS);
      end
      @(posedge clk);
      #1;
      exp_valid = m_valid;
      exp_pool = m_pool;
      exp_fd = m_fd;
      chk_en = 1'b1;
   endtask

   task automatic send_frame(input logic [DW-1:0] f [16], input int gap);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, f[i], 1'b0);
         for (int g = 0; g < gap; g++) step(1'b0, DW'($urandom), 1'b0);
      end
   endtask

   task automatic chk_seq4(input string name, input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                           input logic [DW-1:0] e2, input logic [DW-1:0] e3, input int base);
      logic [DW-1:0] e [4];
      e = '{e0, e1, e2, e3};
      for (int i = 0; i < 4; i++) begin
         chk(name, (base + i < got.size()) ? {16'h0000, got[base + i]} : 32'hFFFF_FFFF,
             {16'h0000, e[i]});
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Compare process: DUT against the model on every cycle, and capture emitted windows.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
         chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
         chk("pool_out", {16'h0000, pool_out}, {16'h0000, exp_pool});
         if (out_valid) got.push_back(pool_out);
         if (frame_done) fd_cyc.push_back(cyc);
      end
   end

   initial begin
      fa = '{16'd1, 16'd5, 16'd2, 16'd3, 16'd4, 16'd0, 16'd7, 16'd6,
             16'd9, 16'd9, 16'd1, 16'd1, 16'd2, 16'd8, 16'd3, 16'd10};
      for (int i = 0; i < 16; i++) fb[i] = 16'h0003;
      fb[15] = 16'h0004;
      fc = '{16'h8000, 16'h7FFF, 16'hFFF0, 16'h8000, 16'h0000, 16'h0001, 16'hFFFF, 16'h8001,
             16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

      step(1'b0, 16'h0000, 1'b1);
      step(1'b1, 16'h1234, 1'b1);
      chk("rst_pool", {16'h0000, pool_out}, 32'd0);
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);

      // Basic frame, continuous valid.
      got.delete(); fd_cyc.delete();
      send_frame(fa, 0);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      chk("basic_cnt", got.size(), 32'd4);
      chk_seq4("basic_val", 16'd5, 16'd7, 16'd9, 16'd10, 0);
      chk("basic_fd_cnt", fd_cyc.size(), 32'd1);

      // Same frame with 3-cycle gaps.
      got.delete(); fd_cyc.delete();
      send_frame(fa, 3);
      step(1'b0, 16'h0000, 1'b0);
      chk("gap_cnt", got.size(), 32'd4);
      chk_seq4("gap_val", 16'd5, 16'd7, 16'd9, 16'd10, 0);

      // Back-to-back frames.
      got.delete(); fd_cyc.delete();
      send_frame(fa, 0);
      send_frame(fb, 0);
      step(1'b0, 16'h0000, 1'b0);
      step(1'b0, 16'h0000, 1'b0);
      chk("b2b_cnt", got.size(), 32'd8);
      chk_seq4("b2b_f1", 16'd5, 16'd7, 16'd9, 16'd10, 0);
      chk_seq4("b2b_f2", 16'd3, 16'd3, 16'd3, 16'd4, 4);
      chk("b2b_fd_cnt", fd_cyc.size(), 32'd2);
      chk("b2b_fd_gap", (fd_cyc.size() == 2) ? fd_cyc[1] - fd_cyc[0] : -1, 32'd16);

      // Reset mid-frame, then a fresh frame.
      for (int i = 0; i < 6; i++) step(1'b1, fa[i], 1'b0);
      step(1'b1, 16'h00FF, 1'b1);
      step(1'b1, 16'h00FF, 1'b1);
      chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
      got.delete(); fd_cyc.delete();
      send_frame(fa, 0);
      step(1'b0, 16'h0000, 1'b0);
      chk("rst_mid_cnt", got.size(), 32'd4);
      chk_seq4("rst_mid_val", 16'd5, 16'd7, 16'd9, 16'd10, 0);

      // Sign-bit windows: behaviour depends on the ReLU build option.
      got.delete(); fd_cyc.delete();
      send_frame(fc, 0);
      step(1'b0, 16'h0000, 1'b0);
      chk("relu_cnt", got.size(), 32'd4);
`ifdef CONV_MAXPOOL_RELU_EN
      chk_seq4("relu_on", 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 0);
`else
      chk_seq4("relu_off", 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 0);
`endif

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
